fadd_arb: RTL and testbench

FADD_ARB -- requirements
Module: fadd_arb

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fadd_rr_arb.sv | 36 +++
 rtl/fadd_arb.sv | 119 +++++++++++
 tb/tb_fadd_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue logic: rounding modes, default pipeline
// depth, owner tag width and the operand bundle carried into the datapath.
package fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RDN = 2'b01,
    RM_RUP = 2'b10,
    RM_RTZ = 2'b11
  } rm_e;

  localparam int FADD_LAT_DEFAULT = 3;
  localparam int OWNER_W          = 1;

  // Which requester won the most recent transfer; the other one wins the next tie.
  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } rr_last_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    rm_e         rm;
  } fadd_op_t;

  function automatic fadd_op_t make_op(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic [1:0] rm);
    fadd_op_t op;
    op.a   = a;
    op.b   = b;
    op.sub = sub;
    op.rm  = rm_e'(rm);
    return op;
  endfunction

endpackage

// File: rtl/fadd_rr_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// requester that did not win last; the pointer moves only when a grant is taken.
module fadd_rr_arb
  import fpu_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  input  logic               req0,
  input  logic               req1,
  input  logic               xfer,
  output logic               gnt_v,
  output logic [OWNER_W-1:0] gnt_idx
);

  rr_last_e last_q;

  always_comb begin
    gnt_v   = req0 | req1;
    gnt_idx = OWNER_W'(0);
    if (req0 && req1) begin
      gnt_idx = (last_q == LAST_REQ0) ? OWNER_W'(1) : OWNER_W'(0);
    end else if (req1) begin
      gnt_idx = OWNER_W'(1);
    end
  end

  // Reset value makes req0 the winner of the first tie.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_q <= LAST_REQ1;
    end else if (xfer) begin
      last_q <= (gnt_idx == OWNER_W'(1)) ? LAST_REQ1 : LAST_REQ0;
    end
  end

endmodule

// File: rtl/fadd_arb.sv
// Issue/response arbiter for two requesters sharing one LAT-deep fadd pipeline.
// An owner tag travels alongside each operation so the result is routed back.
module fadd_arb
  import fpu_pkg::*;
#(
  parameter int LAT = FADD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_v,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic [1:0]  req0_rm,
  output logic        req0_rdy,
  input  logic        req1_v,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  input  logic [1:0]  req1_rm,
  output logic        req1_rdy,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_sub,
  output logic [1:0]  dp_rm,
  output logic        dp_en,
  input  logic [31:0] dp_s,
  output logic        rsp0_v,
  output logic [31:0] rsp0_s,
  input  logic        rsp0_ack,
  output logic        rsp1_v,
  output logic [31:0] rsp1_s,
  input  logic        rsp1_ack,
  input  logic        flush,
  output logic        busy
);

  logic [LAT-1:0]     v_q;
  logic [OWNER_W-1:0] owner_q [LAT];

  logic               req0_live;
  logic               req1_live;
  logic               gnt_v;
  logic [OWNER_W-1:0] gnt_idx;
  logic               xfer;
  logic               tail_v;
  logic [OWNER_W-1:0] tail_own;
  logic               tail_ack;
  fadd_op_t           sel_op;

  // Requests are masked during reset so nothing is granted or driven onto dp_*.
  assign req0_live = req0_v & clrn;
  assign req1_live = req1_v & clrn;

  fadd_rr_arb u_arb (
    .clk     (clk),
    .clrn    (clrn),
    .req0    (req0_live),
    .req1    (req1_live),
    .xfer    (xfer),
    .gnt_v   (gnt_v),
    .gnt_idx (gnt_idx)
  );

  assign tail_v   = v_q[LAT-1];
  assign tail_own = owner_q[LAT-1];
  assign tail_ack = (tail_own == OWNER_W'(1)) ? rsp1_ack : rsp0_ack;

  // The whole pipeline freezes only while a finished result waits for its ack.
  assign dp_en = ~(tail_v & ~tail_ack);

  assign req0_rdy = gnt_v & (gnt_idx == OWNER_W'(0)) & dp_en & ~flush;
  assign req1_rdy = gnt_v & (gnt_idx == OWNER_W'(1)) & dp_en & ~flush;
  assign xfer     = req0_rdy | req1_rdy;

  always_comb begin
    sel_op = '0;
    if (gnt_v) begin
      if (gnt_idx == OWNER_W'(1)) begin
        sel_op = make_op(req1_a, req1_b, req1_sub, req1_rm);
      end else begin
        sel_op = make_op(req0_a, req0_b, req0_sub, req0_rm);
      end
    end
  end

  assign dp_a   = sel_op.a;
  assign dp_b   = sel_op.b;
  assign dp_sub = sel_op.sub;
  assign dp_rm  = sel_op.rm;

  assign rsp0_v = tail_v & (tail_own == OWNER_W'(0)) & ~flush;
  assign rsp1_v = tail_v & (tail_own == OWNER_W'(1)) & ~flush;
  assign rsp0_s = rsp0_v ? dp_s : 32'd0;
  assign rsp1_s = rsp1_v ? dp_s : 32'd0;

  assign busy = |v_q;

  // Valid/owner tracking mirrors the datapath stages; a flush only kills valids.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        owner_q[i] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else if (dp_en) begin
      v_q        <= {v_q[LAT-2:0], xfer};
      owner_q[0] <= gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  a_one_rdy : assert property (@(posedge clk) disable iff (!clrn) !(req0_rdy && req1_rdy));

endmodule

// File: tb/tb_fadd_arb.sv
// Bench for fadd_arb: the bench plays both requesters, both responders and the
// fadd datapath, and tracks in-flight operations as a list with per-op progress.
module tb_fadd_arb;
  import fpu_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req0_v, req1_v, req0_sub, req1_sub, req0_rdy, req1_rdy;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_rm, req1_rm;
  logic [31:0] dp_a, dp_b, dp_s;
  logic        dp_sub, dp_en;
  logic [1:0]  dp_rm;
  logic        rsp0_v, rsp1_v, rsp0_ack, rsp1_ack, flush, busy;
  logic [31:0] rsp0_s, rsp1_s;

  fadd_arb #(.LAT(LAT)) dut (
    .clk(clk), .clrn(clrn),
    .req0_v(req0_v), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req0_rm(req0_rm), .req0_rdy(req0_rdy),
    .req1_v(req1_v), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .req1_rm(req1_rm), .req1_rdy(req1_rdy),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_rm(dp_rm), .dp_en(dp_en), .dp_s(dp_s),
    .rsp0_v(rsp0_v), .rsp0_s(rsp0_s), .rsp0_ack(rsp0_ack),
    .rsp1_v(rsp1_v), .rsp1_s(rsp1_s), .rsp1_ack(rsp1_ack),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real sp_to_real(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  // Exact for the small integer operands used here; an exact-zero sum follows the rm sign rule.
  function automatic logic [31:0] real_to_sp(input real r, input logic [1:0] rm);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return (rm == RM_RDN) ? 32'h8000_0000 : 32'h0000_0000;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic [1:0] rm);
    real s;
    s = sub ? sp_to_real(a) - sp_to_real(b) : sp_to_real(a) + sp_to_real(b);
    return real_to_sp(s, rm);
  endfunction

  logic [31:0] dp_pipe [LAT] = '{default: 32'd0};
  always @(posedge clk) begin
    if (dp_en) begin
      for (int i = LAT - 1; i > 0; i--) dp_pipe[i] <= dp_pipe[i-1];
      dp_pipe[0] <= fadd_ref(dp_a, dp_b, dp_sub, dp_rm);
    end
  end
  assign dp_s = dp_pipe[LAT-1];

  logic        pend   [2];
  logic [31:0] op_a   [2];
  logic [31:0] op_b   [2];
  logic        op_sub [2];
  logic [1:0]  op_rm  [2];
  logic        ack    [2];
  logic        flush_i;

  typedef struct {
    int          owner;
    logic [31:0] res;
    int          stage;
  } flight_t;
  flight_t inflight [$];
  int      last_gnt;

  logic exp_en, exp_rdy0, exp_rdy1;
  logic snap_rdy0, snap_rdy1, snap_en, snap_busy, snap_rsp0_v, snap_rsp1_v;
  logic [31:0] snap_rsp0_s, snap_rsp1_s;

  int n_compared = 0;
  int n_mismatch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic newOp(input int n);
    int ka, kb;
    ka = int'($urandom_range(100, 1));
    kb = int'($urandom_range(100, 1));
    if ($urandom_range(1, 0) == 1) ka = -ka;
    if ($urandom_range(1, 0) == 1) kb = -kb;
    pend[n]   = 1'b1;
    op_a[n]   = real_to_sp(real'(ka), 2'b00);
    op_b[n]   = real_to_sp(real'(kb), 2'b00);
    op_sub[n] = 1'($urandom_range(1, 0));
    op_rm[n]  = 2'($urandom_range(3, 0));
    if ($urandom_range(3, 0) == 0) op_b[n] = op_sub[n] ? op_a[n] : (op_a[n] ^ 32'h8000_0000);
  endtask

  task automatic applyStimulus();
    req0_v = pend[0]; req0_a = op_a[0]; req0_b = op_b[0]; req0_sub = op_sub[0]; req0_rm = op_rm[0];
    req1_v = pend[1]; req1_a = op_a[1]; req1_b = op_b[1]; req1_sub = op_sub[1]; req1_rm = op_rm[1];
    rsp0_ack = ack[0];
    rsp1_ack = ack[1];
    flush = flush_i;
  endtask

  task automatic checkOutput();
    int          g;
    logic        at_end, exp_rv0, exp_rv1;
    logic [31:0] e_a, e_b;
    logic        e_sub;
    logic [1:0]  e_rm;
    g = -1;
    if (pend[0] && pend[1]) g = (last_gnt == 0) ? 1 : 0;
    else if (pend[0]) g = 0;
    else if (pend[1]) g = 1;
    at_end   = (inflight.size() > 0) && (inflight[0].stage == LAT - 1);
    exp_en   = !(at_end && !ack[at_end ? inflight[0].owner : 0]);
    exp_rdy0 = (g == 0) && exp_en && !flush_i;
    exp_rdy1 = (g == 1) && exp_en && !flush_i;
    exp_rv0  = at_end && (inflight[0].owner == 0) && !flush_i;
    exp_rv1  = at_end && (inflight[0].owner == 1) && !flush_i;
    e_a = (g >= 0) ? op_a[g] : 32'd0;
    e_b = (g >= 0) ? op_b[g] : 32'd0;
    e_sub = (g >= 0) ? op_sub[g] : 1'b0;
    e_rm  = (g >= 0) ? op_rm[g] : 2'd0;
    check("req0_rdy", 32'(req0_rdy), 32'(exp_rdy0));
    check("req1_rdy", 32'(req1_rdy), 32'(exp_rdy1));
    check("dp_en", 32'(dp_en), 32'(exp_en));
    check("dp_a", dp_a, e_a);
    check("dp_b", dp_b, e_b);
    check("dp_sub_rm", 32'({dp_sub, dp_rm}), 32'({e_sub, e_rm}));
    check("rsp0_v", 32'(rsp0_v), 32'(exp_rv0));
    check("rsp1_v", 32'(rsp1_v), 32'(exp_rv1));
    check("rsp0_s", rsp0_s, exp_rv0 ? inflight[0].res : 32'd0);
    check("rsp1_s", rsp1_s, exp_rv1 ? inflight[0].res : 32'd0);
    check("busy", 32'(busy), 32'(inflight.size() > 0));
    snap_rdy0 = req0_rdy; snap_rdy1 = req1_rdy; snap_en = dp_en; snap_busy = busy;
    snap_rsp0_v = rsp0_v; snap_rsp1_v = rsp1_v; snap_rsp0_s = rsp0_s; snap_rsp1_s = rsp1_s;
  endtask

  task automatic updateModel();
    flight_t f;
    int      n;
    if (flush_i) begin
      inflight.delete();
    end else if (exp_en) begin
      for (int i = 0; i < inflight.size(); i++) inflight[i].stage++;
      if (inflight.size() > 0 && inflight[0].stage > LAT - 1) void'(inflight.pop_front());
      if (exp_rdy0 || exp_rdy1) begin
        n = exp_rdy0 ? 0 : 1;
        f.owner = n;
        f.res   = fadd_ref(op_a[n], op_b[n], op_sub[n], op_rm[n]);
        f.stage = 0;
        inflight.push_back(f);
        last_gnt = n;
        pend[n]  = 1'b0;
      end
    end
  endtask

  task automatic step();
    applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    if (clrn) updateModel();
    #1;
  endtask

  task automatic drain(input int n);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (n) step();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_rdy"}, 32'({req0_rdy, req1_rdy}), 32'd0);
    check({tag, "_rspv"}, 32'({rsp0_v, rsp1_v}), 32'd0);
    check({tag, "_rsp0_s"}, rsp0_s, 32'd0);
    check({tag, "_rsp1_s"}, rsp1_s, 32'd0);
    check({tag, "_dp_ab"}, dp_a | dp_b, 32'd0);
    check({tag, "_dp_sub_rm"}, 32'({dp_sub, dp_rm}), 32'd0);
    check({tag, "_dp_en"}, 32'(dp_en), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; op_a[n] = '0; op_b[n] = '0; op_sub[n] = 1'b0; op_rm[n] = 2'd0; ack[n] = 1'b1;
    end
    flush_i  = 1'b0;
    last_gnt = 1;

    // Reset held with both requesters asking: everything must stay quiet.
    newOp(0);
    newOp(1);
    applyStimulus();
    #2;
    checkResetOutputs("por");
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    @(posedge clk);
    #1 clrn = 1'b1;

    // 1.0 + 2.0 on req0 returns 3.0 exactly LAT cycles after acceptance.
    pend[0] = 1'b1; op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000; op_sub[0] = 1'b0; op_rm[0] = 2'b00;
    step();
    check("add_accept", 32'(snap_rdy0), 32'd1);
    for (int i = 1; i < LAT; i++) begin
      step();
      check("add_early", 32'(snap_rsp0_v), 32'd0);
    end
    step();
    check("add_rsp_v", 32'(snap_rsp0_v), 32'd1);
    check("add_rsp_s", snap_rsp0_s, 32'h4040_0000);

    // Both requesters always pending: grants alternate, req1 first since req0 won last.
    for (int i = 0; i < 8; i++) begin
      if (!pend[0]) newOp(0);
      if (!pend[1]) newOp(1);
      step();
      check("rr_alt_r1", 32'(snap_rdy1), 32'((i % 2) == 0));
      check("rr_alt_r0", 32'(snap_rdy0), 32'((i % 2) == 1));
    end
    drain(LAT + 1);

    // 2.0 - 1.0 on req1 with its ack held low: the pipeline and req0 must wait.
    pend[1] = 1'b1; op_a[1] = 32'h4000_0000; op_b[1] = 32'h3F80_0000; op_sub[1] = 1'b1; op_rm[1] = 2'b00;
    ack[1] = 1'b0;
    step();
    check("sub_accept", 32'(snap_rdy1), 32'd1);
    repeat (LAT - 1) step();
    newOp(0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_en", 32'(snap_en), 32'd0);
      check("stall_rsp1_s", snap_rsp1_s, 32'h3F80_0000);
      check("stall_rdy0", 32'(snap_rdy0), 32'd0);
    end
    ack[1] = 1'b1;
    step();
    check("stall_release_rdy0", 32'(snap_rdy0), 32'd1);
    drain(LAT + 1);

    // Flush with three ops in flight and a fourth pending.
    for (int i = 0; i < 3; i++) begin
      newOp(0);
      step();
      check("fl_issue", 32'(snap_rdy0), 32'd1);
    end
    newOp(0);
    flush_i = 1'b1;
    step();
    check("fl_rdy", 32'(snap_rdy0), 32'd0);
    check("fl_rspv", 32'({snap_rsp0_v, snap_rsp1_v}), 32'd0);
    flush_i = 1'b0;
    step();
    check("fl_busy_after", 32'(snap_busy), 32'd0);
    check("fl_pending_taken", 32'(snap_rdy0), 32'd1);
    drain(LAT + 2);

    // Randomised traffic, backpressure and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(2, 0) == 0) newOp(n);
        ack[n] = ($urandom_range(3, 0) != 0);
      end
      flush_i = ($urandom_range(32, 0) == 0);
      step();
    end
    flush_i = 1'b0;
    ack[0] = 1'b1;
    ack[1] = 1'b1;

    // Reset dropped mid-stream between edges.
    for (int i = 0; i < 2; i++) begin
      if (!pend[0]) newOp(0);
      if (!pend[1]) newOp(1);
      step();
    end
    if (!pend[0]) newOp(0);
    if (!pend[1]) newOp(1);
    applyStimulus();
    #2 clrn = 1'b0;
    #1;
    checkResetOutputs("mid");
    inflight.delete();
    last_gnt = 1;
    @(posedge clk);
    #1 clrn = 1'b1;
    step();
    check("post_rst_r0", 32'(snap_rdy0), 32'd1);
    check("post_rst_r1", 32'(snap_rdy1), 32'd0);
    drain(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
